// File: rtl/cache_fill_cwf_param.sv
// rtl/cache_fill_fsm_param.sv - parametrised cache-line fill controller
//
// Purpose:
//   On a cache miss, issues one read per cycle for every word of the line to
//   a pipelined, in-order memory port. Each returning word is written into
//   the data array at its word index. The tag is written once the line is
//   complete.
//
// Optional feature:
//   Define CACHE_FILL_CWF_EN to enable critical-word-first ordering. The
//   missed word is then requested and written first, and the remaining words
//   wrap modulo the line. Without the macro, words are requested at
//   ascending offsets from the line base.
//
// Ports:
//   clk               in   clock, rising edge
//   rst               in   synchronous active-high reset
//   miss_detected     in   tag logic reports a miss on miss_address
//   miss_address      in   byte address that missed
//   fsm_busy          out  fill in progress (pipeline stall), combinational
//   memory_read       out  registered read request strobe
//   memory_address    out  registered byte address of the current request
//   memory_data       in   returned word (write data for the data array)
//   memory_data_valid in   memory_data valid this cycle
//   write_data_array  out  data-array write enable
//   fill_word_idx     out  data-array word index for write_data_array
//   write_tag_array   out  one-cycle tag-array write enable
module cache_fill_fsm_param #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int BYTES_PER_WORD  = 2,
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK),
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK * BYTES_PER_WORD),
    localparam int BW_W  = $clog2(BYTES_PER_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              memory_read,
    output logic [ADDR_W-1:0] memory_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              write_data_array,
    output logic [IDX_W-1:0]  fill_word_idx,
    output logic              write_tag_array
);

    // The request counter needs one extra bit to represent "all issued".
    localparam int REQ_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_TAG
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_base;
    logic [IDX_W-1:0]   r_start;
    logic [REQ_W-1:0]   r_req_cnt;
    logic [IDX_W-1:0]   r_rsp_cnt;

    logic [ADDR_W-1:0]  w_base_new;
    logic [IDX_W-1:0]   w_start_new;
    logic [IDX_W-1:0]   w_req_idx;
    logic               w_req_pending;
    logic               w_unused;

    // Word index -> byte offset within the line. The index is already
    // truncated modulo the line, so the line address bits are never touched.
    function automatic logic [ADDR_W-1:0] f_offset(input logic [IDX_W-1:0] idx);
        return {{(ADDR_W-IDX_W){1'b0}}, idx} << BW_W;
    endfunction

    assign w_base_new = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef CACHE_FILL_CWF_EN
    assign w_start_new = miss_address[OFF_W-1:BW_W];
`else
    assign w_start_new = '0;
`endif

    assign w_req_idx     = r_start + r_req_cnt[IDX_W-1:0];
    assign w_req_pending = (r_req_cnt < REQ_W'(WORDS_PER_BLOCK));

    // memory_data is consumed by the data array directly; the low address
    // bits only matter when critical-word-first is enabled.
    assign w_unused = ^{memory_data, miss_address[OFF_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        fsm_busy         = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_word_idx    = '0;
        case (r_state)
            S_IDLE: begin
                // Stall in the miss cycle itself, before the state changes.
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                fsm_busy         = 1'b1;
                write_data_array = memory_data_valid;
                fill_word_idx    = r_start + r_rsp_cnt;
                if (memory_data_valid && (r_rsp_cnt == IDX_W'(WORDS_PER_BLOCK - 1))) begin
                    w_next = S_TAG;
                end
            end
            S_TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                w_next          = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Keep every output quiet while reset is asserted.
        if (rst) begin
            fsm_busy         = 1'b0;
            write_data_array = 1'b0;
            write_tag_array  = 1'b0;
            fill_word_idx    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base         <= '0;
            r_start        <= '0;
            r_req_cnt      <= '0;
            r_rsp_cnt      <= '0;
            memory_read    <= 1'b0;
            memory_address <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    memory_read <= 1'b0;
                    if (miss_detected) begin
                        r_base         <= w_base_new;
                        r_start        <= w_start_new;
                        memory_read    <= 1'b1;
                        memory_address <= w_base_new | f_offset(w_start_new);
                        r_req_cnt      <= REQ_W'(1);
                        r_rsp_cnt      <= '0;
                    end
                end
                S_FILL: begin
                    if (w_req_pending) begin
                        memory_read    <= 1'b1;
                        memory_address <= r_base | f_offset(w_req_idx);
                        r_req_cnt      <= r_req_cnt + 1'b1;
                    end else begin
                        // Address holds its last value once all reads are out.
                        memory_read <= 1'b0;
                    end
                    if (memory_data_valid) begin
                        r_rsp_cnt <= r_rsp_cnt + 1'b1;
                    end
                end
                S_TAG: begin
                    memory_read <= 1'b0;
                    r_req_cnt   <= '0;
                    r_rsp_cnt   <= '0;
                end
                default: begin
                    memory_read <= 1'b0;
                end
            endcase
        end
    end

endmodule
